// File: rtl/cpu_pkg.sv
// Shared datapath definitions: word width, payload field widths and the
// occupancy encoding used by the two-entry skid buffer.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int ERR_W  = 1;

  // Occupancy of the output stage (main register plus skid register).
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Payload layout, MSB first: {word, select, err}.
  function automatic int payload_w(input int word_w, input int sel_w);
    return word_w + sel_w + ERR_W;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer. The main register drives the outputs directly; the
// skid register catches the one beat that can arrive while the consumer is
// stalled, so in_ready can be a registered signal without losing beats.
module skid_buf2
  import cpu_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  buf_state_e    state_p0;
  buf_state_e    next_state;
  logic [PW-1:0] main_p0;
  logic [PW-1:0] skid_p1;
  logic          vld_p0;
  logic          accept;
  logic          drain;

  assign vld_p0 = (state_p0 != BUF_EMPTY);
  assign accept = in_valid & in_ready;
  assign drain  = vld_p0 & out_ready;

  // Occupancy transition: accept adds a beat, drain removes one.
  always_comb begin
    next_state = state_p0;
    case (state_p0)
      BUF_EMPTY: if (accept) next_state = BUF_ONE;
      BUF_ONE: begin
        if (accept && !drain)      next_state = BUF_TWO;
        else if (!accept && drain) next_state = BUF_EMPTY;
        else                       next_state = BUF_ONE;
      end
      BUF_TWO:   if (drain) next_state = BUF_ONE;
      default:   next_state = BUF_EMPTY;
    endcase
  end

  // State, registered ready, and the main/skid payload registers.
  // in_ready looks one state ahead, so an accept can never land in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= BUF_EMPTY;
      in_ready <= 1'b0;
      main_p0  <= '0;
      skid_p1  <= '0;
    end else begin
      state_p0 <= next_state;
      in_ready <= (next_state != BUF_TWO);
      case (state_p0)
        BUF_EMPTY: begin
          if (accept) main_p0 <= in_payload;
        end
        BUF_ONE: begin
          // Older beat stays in main while stalled; newer one parks in skid.
          if (accept && !drain)     skid_p1 <= in_payload;
          else if (accept && drain) main_p0 <= in_payload;
        end
        BUF_TWO: begin
          if (drain) main_p0 <= skid_p1;
        end
        default: begin
          main_p0 <= main_p0;
        end
      endcase
    end
  end

  // ---- output stage ----
  assign out_valid   = vld_p0;
  assign out_payload = main_p0;

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined N-input word selector. Picks one of NUM_IN words per accepted
// beat (optionally reusing the last unlocked select) and hands the beat to a
// two-entry skid buffer that presents it one cycle later.
module mux_pipe_n
  import cpu_pkg::*;
#(
  parameter  int WIDTH  = WORD_W,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    sel_lock,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err
);

  localparam int PW = payload_w(WIDTH, SEL_W);

  logic [SEL_W-1:0] sel_q_p0;
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] word;
  logic             err;
  logic             accept;
  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    pay_out;

  assign accept  = in_valid & in_ready;
  assign eff_sel = sel_lock ? sel_q_p0 : in_sel;

  // NUM_IN need not be a power of two, so some select codes name no channel.
  assign err = (int'(eff_sel) >= NUM_IN);

  // N:1 word pick; an out-of-range select leaves the word at zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(eff_sel) == i) word = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Held select: follows in_sel on every unlocked accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q_p0 <= '0;
    end else if (accept && !sel_lock) begin
      sel_q_p0 <= in_sel;
    end
  end

  assign pay_in = {word, eff_sel, err};

  // ---- accept stage -> output stage ----
  skid_buf2 #(
    .PW (PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (pay_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (pay_out)
  );

  assign out_data = pay_out[PW-1 -: WIDTH];
  assign out_sel  = pay_out[ERR_W +: SEL_W];
  assign out_err  = pay_out[0];

endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n with NUM_IN=6 (select codes 6,7 are out of
// range). A predictor pushes the expected beat on every accept; a monitor
// compares the presented beat against the queue head and pops on drain.
module tb_mux_pipe_n;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int SW = 3;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          e;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sel;
  logic            sel_lock;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   msel = 0;
  bit   rdy_m = 0;
  bit   fixed_pat = 1;
  int   n_acc = 0;

  mux_pipe_n #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .sel_lock  (sel_lock),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge.
  task automatic cyc(input bit v, input int s, input bit l, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_sel    = 3'(s);
    sel_lock  = l;
    out_ready = r;
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = fixed_pat ? (32'hA000_0000 + 32'(i)) : $urandom;
  endtask

  // Predictor: reference behaviour from the select/lock rules.
  initial begin
    exp_t e;
    int   eff;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (in_valid && in_ready) begin
          eff = sel_lock ? msel : int'(in_sel);
          e.s = 3'(eff);
          e.e = (eff >= N);
          e.d = e.e ? '0 : in_data[eff*W +: W];
          q.push_back(e);
          if (!sel_lock) msel = int'(in_sel);
          n_acc++;
        end
        rdy_m = (q.size() != 2);
      end
    end
  end

  // Monitor: compares the presented beat and handshake against the model.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(rdy_m));
        if (out_valid && q.size() != 0) begin
          chk("out_data", 64'(out_data), 64'(q[0].d));
          chk("out_sel", 64'(out_sel), 64'(q[0].s));
          chk("out_err", 64'(out_err), 64'(q[0].e));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_sel"}, 64'(out_sel), 64'd0);
    chk({tag, "_out_err"}, 64'(out_err), 64'd0);
  endtask

  initial begin
    int bp_sel;
    int acc0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    sel_lock  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat, then streaming including out-of-range codes.
    cyc(1, 5, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int s = 0; s < 8; s++) cyc(1, s, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Back-pressure: four stalled cycles offering 1,2,3.
    acc0   = n_acc;
    bp_sel = 1;
    for (int k = 0; k < 4; k++) begin
      cyc(1, bp_sel, 0, 0);
      #4;
      if (in_valid && in_ready) bp_sel++;
    end
    chk("bp_accepted", 64'(n_acc - acc0), 64'd2);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);

    // Lock sequence 3, (6 locked), 2 and out-of-range 7 then 4.
    cyc(1, 3, 0, 1);
    cyc(1, 6, 1, 1);
    cyc(1, 2, 0, 1);
    cyc(1, 7, 0, 1);
    cyc(1, 4, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Mid-run reset with two beats held.
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    msel  = 0;
    rdy_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // Locked first beat after reset must use channel 0.
    cyc(1, 4, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Randomized traffic.
    fixed_pat = 0;
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7),
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised, pipelined N-input word selector with a valid/ready handshake, a 2-entry skid buffer, and an optional selection lock. It is the general-purpose successor of the datapath's fixed 8-way word mux. It sits between a producer stage, such as the register-read or result-collect stage, and a consumer that may stall. It picks one of NUM_IN words per accepted beat and presents it one cycle later without dropping or duplicating beats under back-pressure.

## Interface
- WIDTH, 32: bits per data word.
- NUM_IN, 8: number of input channels, range 2..64. Need not be a power of two.
- SEL_W, $clog2(NUM_IN): select width. Local, derived, not overridable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  block can accept a beat (registered).
- in_sel  in  SEL_W  binary channel index for this beat.
- sel_lock  in  1  1 = ignore in_sel and reuse the held selection.
- in_data  in  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  WIDTH  selected word.
- out_sel  out  SEL_W  channel index that produced out_data.
- out_err  out  1  beat carried an out-of-range select.

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Effective select `eff_sel` = sel_lock ? sel_q : in_sel.
- sel_q updates to in_sel on every accept with sel_lock=0. sel_q is unchanged when sel_lock=1 or when there is no accept.
- Beat payload = {word, eff_sel, err}. word = channel eff_sel. If eff_sel >= NUM_IN, word = 0 and err = 1.
- Storage is a main register driving the outputs plus one skid register. Beats leave in strict accept order.
- State machine:
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & !drain -> TWO.
    - accept & drain -> ONE; the new beat replaces main.
    - !accept & drain -> EMPTY.
    - no accept and no drain -> ONE.
  - TWO: drain -> ONE, skid moves to main. Otherwise hold.
- in_ready = registered (next_state != TWO). Accept is impossible in TWO, so overflow cannot occur.
- out_valid = (state != EMPTY).
- Output payload is stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=EMPTY, in_ready=0, out_valid=0.
  - out_data=0, out_sel=0, out_err=0, sel_q=0, skid register=0.
- First rising edge after rst_n deasserts: in_ready=1.
- Latency: a beat accepted at edge k appears on outputs after edge k. It is visible in cycle k+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure: out_ready low with in_valid high fills ONE and then TWO. in_ready drops in the cycle after the second accept. At most 2 beats are accepted while out_ready is low.
- Recovery: in TWO, a drain returns the block to ONE. in_ready reasserts the following cycle.
- Simultaneous accept and drain in ONE: no occupancy change and no bubble.
- sel_lock=1 on the very first beat after reset selects channel 0.
- Reset mid-operation discards all held beats. No partial beat is ever emitted.

## Structure
- Shared package `cpu_pkg`: WORD_W=32 constant and the payload struct-equivalent field widths. mux_pipe_n defaults WIDTH from WORD_W.
- One sub-module, `skid_buf2`, is natural. It is parametrised by payload width and holds the EMPTY/ONE/TWO state machine, the main and skid registers, and in_ready. The top holds the select/lock logic and the combinational N:1 word pick.

## Test plan
- Reset then a single beat: NUM_IN=8, in_sel=5, channel i word = 32'hA000_0000+i, out_ready=1 -> next cycle out_valid=1, out_data=32'hA000_0005, out_sel=5, out_err=0, and in_ready stays 1.
- Streaming: selects 0..7 on consecutive cycles, out_ready=1 -> outputs 0..7 in order, one per cycle, no bubbles.
- Back-pressure:
  - Stimulus: out_ready=0 for 4 cycles with in_valid=1 and selects 1,2,3 offered.
  - Response: exactly beats 1 and 2 accepted and in_ready=0. After out_ready rises, 1 then 2 emerge and in_ready returns to 1 one cycle after the first drain.
- Lock: accept sel=3 with lock=0, then sel=6 with lock=1, then sel=2 with lock=0 -> out_sel sequence 3,3,2.
- Out-of-range: NUM_IN=6, in_sel=7 -> out_data=0, out_err=1, out_sel=7. The next beat with sel=4 gives out_err=0.
- Mid-run reset: TWO state, rst_n pulsed low between edges -> out_valid=0 and out_data=0 immediately. No stale beat appears after release.
